// File: rtl/gpio_bank.sv
// N-pin GPIO bank on the simple register bus: direction, atomic SET/CLR/TGL,
// two-flop input synchroniser, edge-capture STATUS (W1C) and level irq.
// Optional per-pin input debounce filter is built when GPIO_DEBOUNCE_EN is defined.
module gpio_bank #(
  parameter int N               = 10,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [5:0]   addr,
  input  logic [31:0]  wdata,
  output logic [31:0]  rdata,
  input  logic         we,
  input  logic         re,
  inout  wire  [N-1:0] gpio,
  output logic         irq
);

  logic [N-1:0] out_q, out_d;
  logic [N-1:0] dir_q, dir_d;
  logic [N-1:0] rise_en_q, rise_en_d;
  logic [N-1:0] fall_en_q, fall_en_d;
  logic [N-1:0] status_q, status_d;
  logic [N-1:0] sync1_q, sync2_q, prev_q;
  logic [N-1:0] f;
  logic [31:0]  rdata_q, rdata_d;
  logic [31:0]  rd_word;
  logic [N-1:0] wd;
  logic [3:0]   word;
  logic [N-1:0] rise, fall;
  logic         unused_bits;

  assign word        = addr[5:2];
  assign wd          = wdata[N-1:0];
  assign unused_bits = ^{addr[1:0], wdata, DEBOUNCE_CYCLES[0]};

  for (genvar gi = 0; gi < N; gi++) begin : g_pad
    assign gpio[gi] = dir_q[gi] ? out_q[gi] : 1'bz;
  end

`ifdef GPIO_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  // f only follows sync2 once it has disagreed for DEBOUNCE_CYCLES straight cycles.
  for (genvar gi = 0; gi < N; gi++) begin : g_deb
    logic [CW-1:0] cnt_q;
    logic          f_bit_q;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q   <= '0;
        f_bit_q <= 1'b0;
      end else if (sync2_q[gi] == f_bit_q) begin
        cnt_q   <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        cnt_q   <= '0;
        f_bit_q <= sync2_q[gi];
      end else begin
        cnt_q   <= cnt_q + 1'b1;
      end
    end
    assign f[gi] = f_bit_q;
  end
`else
  assign f = sync2_q;
`endif

  assign rise = f & ~prev_q & rise_en_q;
  assign fall = ~f & prev_q & fall_en_q;

  always_comb begin
    out_d     = out_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    status_d  = status_q;
    if (we) begin
      case (word)
        4'd0: out_d     = wd;
        4'd2: dir_d     = wd;
        4'd3: out_d     = out_q | wd;
        4'd4: out_d     = out_q & ~wd;
        4'd5: out_d     = out_q ^ wd;
        4'd6: rise_en_d = wd;
        4'd7: fall_en_d = wd;
        4'd8: status_d  = status_q & ~wd;
        default: ;
      endcase
    end
    // New edges are ORed in after the W1C so a coincident set is never lost.
    status_d = status_d | rise | fall;
  end

  always_comb begin
    rd_word = '0;
    case (word)
      4'd0: rd_word[N-1:0] = out_q;
      4'd1: rd_word[N-1:0] = f;
      4'd2: rd_word[N-1:0] = dir_q;
      4'd6: rd_word[N-1:0] = rise_en_q;
      4'd7: rd_word[N-1:0] = fall_en_q;
      4'd8: rd_word[N-1:0] = status_q;
      default: ;
    endcase
    rdata_d = re ? rd_word : rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      rdata_q   <= '0;
    end else begin
      out_q     <= out_d;
      dir_q     <= dir_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      sync1_q   <= gpio;
      sync2_q   <= sync1_q;
      prev_q    <= f;
      rdata_q   <= rdata_d;
    end
  end

  assign rdata = rdata_q;
  assign irq   = |status_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Scenario bench for gpio_bank: expected read data is queued when a read is
// issued and popped once rdata has been loaded.
module tb_gpio_bank;

  localparam logic [5:0] A_OUT = 6'h00, A_IN = 6'h04, A_DIR = 6'h08, A_SET = 6'h0C,
                         A_CLR = 6'h10, A_TGL = 6'h14, A_RISE = 6'h18, A_FALL = 6'h1C,
                         A_STAT = 6'h20;
`ifdef GPIO_DEBOUNCE_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  addr = '0;
  logic [31:0] wdata = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  wire  [31:0] rdata, rdata6;
  tri   [9:0]  gpio;
  tri   [5:0]  gpio6;
  wire         irq, irq6;
  logic [9:0]  tb_oe = '0;
  logic [9:0]  tb_val = '0;

  typedef struct {
    logic [31:0] val;
    string       name;
  } exp_t;
  exp_t sbq[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 10; gi++) begin : g_tbpad
    assign gpio[gi] = tb_oe[gi] ? tb_val[gi] : 1'bz;
  end

  gpio_bank #(.N(10), .DEBOUNCE_CYCLES(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .rdata(rdata),
    .we(we), .re(re), .gpio(gpio), .irq(irq)
  );

  gpio_bank #(.N(6), .DEBOUNCE_CYCLES(4)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .rdata(rdata6),
    .we(we), .re(re), .gpio(gpio6), .irq(irq6)
  );

  // Drives one bus cycle; the following posedge consumes it.
  task automatic bus(input logic w, input logic r, input logic [5:0] a, input logic [31:0] d);
    @(negedge clk);
    we = w; re = r; addr = a; wdata = d;
  endtask

  // Issues a read, queues its expectation and returns once rdata is loaded.
  task automatic rd(input logic [5:0] a, input logic [31:0] v, input string n);
    bus(1'b0, 1'b1, a, 32'h0);
    sbq.push_back('{val: v, name: n});
    bus(1'b0, 1'b0, 6'h0, 32'h0);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got 0x%08h want 0x0", rdata); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b want 0", irq); end
    rst_n = 1'b1;
    rd(A_OUT, 32'h0, "reset_out");
    e = sbq.pop_front(); checks++; if (rdata !== e.val) begin errors++; $display("FAIL %s: got 0x%08h want 0x%08h", e.name, rdata, e.val); end
    rd(A_DIR, 32'h0, "reset_dir");
    e = sbq.pop_front(); checks++; if (rdata !== e.val) begin errors++; $display("FAIL %s: got 0x%08h want 0x%08h", e.name, rdata, e.val); end
    rd(A_STAT, 32'h0, "reset_status");
    e = sbq.pop_front(); checks++; if (rdata !== e.val) begin errors++; $display("FAIL %s: got 0x%08h want 0x%08h", e.name, rdata, e.val); end
    // Pads are released after reset, so the bench can drive every pin and read it back.
    tb_oe = 10'h3FF; tb_val = 10'h2A5;
    repeat (3 + LAT) bus(1'b0, 1'b0, 6'h0, 32'h0);
    rd(A_IN, 32'h2A5, "reset_pads_input");
    e = sbq.pop_front(); checks++; if (rdata !== e.val) begin errors++; $display("FAIL %s: got 0x%08h want 0x%08h", e.name, rdata, e.val); end
    tb_oe = 10'h000;
  endtask

  task automatic test_out_ops;
    logic [5:0]  ops_a [4] = '{A_SET, A_TGL, A_CLR, A_OUT};
    logic [31:0] ops_d [4] = '{32'h005, 32'h00F, 32'h002, 32'hFFFF_FFFF};
    logic [31:0] ops_e [4] = '{32'h005, 32'h00A, 32'h008, 32'h3FF};
    bus(1'b1, 1'b0, A_DIR, 32'h3FF);
    bus(1'b1, 1'b0, A_OUT, 32'h000);
    for (int i = 0; i < 4; i++) begin
      bus(1'b1, 1'b0, ops_a[i], ops_d[i]);
      rd(A_OUT, ops_e[i], $sformatf("out_op%0d", i));
      e = sbq.pop_front(); checks++; if (rdata !== e.val) begin errors++; $display("FAIL %s: got 0x%08h want 0x%08h", e.name, rdata, e.val); end
      if (i == 2) begin
        checks++; if (gpio !== 10'h008) begin errors++; $display("FAIL pad_drive: got 0x%03h want 0x008", gpio); end
      end
    end
    bus(1'b1, 1'b0, A_OUT, 32'h008);
    rd(A_SET, 32'h0, "set_reads_zero");
    e = sbq.pop_front(); checks++; if (rdata !== e.val) begin errors++; $display("FAIL %s: got 0x%08h want 0x%08h", e.name, rdata, e.val); end
    rd(A_DIR, 32'h3FF, "dir_readback");
    e = sbq.pop_front(); checks++; if (rdata !== e.val) begin errors++; $display("FAIL %s: got 0x%08h want 0x%08h", e.name, rdata, e.val); end
  endtask

  task automatic test_rise_irq;
    bus(1'b1, 1'b0, A_DIR, 32'h000);
    tb_oe = 10'h3FF; tb_val = 10'h000;
    repeat (4 + LAT) bus(1'b0, 1'b0, 6'h0, 32'h0);
    bus(1'b1, 1'b0, A_RISE, 32'h001);
    bus(1'b0, 1'b0, 6'h0, 32'h0);
    tb_val[0] = 1'b1;
    repeat (LAT) bus(1'b0, 1'b0, 6'h0, 32'h0);
    bus(1'b0, 1'b1, A_IN, 32'h0);
    sbq.push_back('{val: 32'h000, name: "in_before_k1"});
    bus(1'b0, 1'b1, A_IN, 32'h0);
    sbq.push_back('{val: 32'h001, name: "in_at_k1"});
    e = sbq.pop_front(); checks++; if (rdata !== e.val) begin errors++; $display("FAIL %s: got 0x%08h want 0x%08h", e.name, rdata, e.val); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_before_k2: got %b want 0", irq); end
    bus(1'b0, 1'b0, 6'h0, 32'h0);
    e = sbq.pop_front(); checks++; if (rdata !== e.val) begin errors++; $display("FAIL %s: got 0x%08h want 0x%08h", e.name, rdata, e.val); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_at_k2: got %b want 1", irq); end
    bus(1'b1, 1'b0, A_RISE, 32'h000);
    rd(A_STAT, 32'h001, "status_kept_after_en_clear");
    e = sbq.pop_front(); checks++; if (rdata !== e.val) begin errors++; $display("FAIL %s: got 0x%08h want 0x%08h", e.name, rdata, e.val); end
    bus(1'b1, 1'b0, A_STAT, 32'h001);
    bus(1'b0, 1'b0, 6'h0, 32'h0);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_w1c: got %b want 0", irq); end
    bus(1'b1, 1'b0, A_RISE, 32'h005);
  endtask

  task automatic test_set_wins;
    bus(1'b0, 1'b0, 6'h0, 32'h0);
    tb_val[2] = 1'b1;
    repeat (1 + LAT) bus(1'b0, 1'b0, 6'h0, 32'h0);
    bus(1'b1, 1'b0, A_STAT, 32'h004);
    rd(A_STAT, 32'h004, "set_wins_over_w1c");
    e = sbq.pop_front(); checks++; if (rdata !== e.val) begin errors++; $display("FAIL %s: got 0x%08h want 0x%08h", e.name, rdata, e.val); end
    bus(1'b1, 1'b0, A_STAT, 32'h004);
    bus(1'b0, 1'b0, 6'h0, 32'h0);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL irq_after_w1c2: got %b want 0", irq); end
  endtask

  task automatic test_fall;
    bus(1'b1, 1'b0, A_FALL, 32'h002);
    tb_val[1] = 1'b1;
    repeat (3 + LAT) bus(1'b0, 1'b0, 6'h0, 32'h0);
    rd(A_STAT, 32'h000, "rise_disabled_pin1");
    e = sbq.pop_front(); checks++; if (rdata !== e.val) begin errors++; $display("FAIL %s: got 0x%08h want 0x%08h", e.name, rdata, e.val); end
    tb_val[1] = 1'b0;
    repeat (3 + LAT) bus(1'b0, 1'b0, 6'h0, 32'h0);
    rd(A_STAT, 32'h002, "fall_pin1");
    e = sbq.pop_front(); checks++; if (rdata !== e.val) begin errors++; $display("FAIL %s: got 0x%08h want 0x%08h", e.name, rdata, e.val); end
    bus(1'b1, 1'b0, A_STAT, 32'h002);
    bus(1'b1, 1'b0, A_FALL, 32'h000);
  endtask

  task automatic test_misc;
    bus(1'b1, 1'b0, 6'h24, 32'hFFFF_FFFF);
    rd(6'h24, 32'h0, "unmapped_0x24");
    e = sbq.pop_front(); checks++; if (rdata !== e.val) begin errors++; $display("FAIL %s: got 0x%08h want 0x%08h", e.name, rdata, e.val); end
    rd(6'h3C, 32'h0, "unmapped_0x3c");
    e = sbq.pop_front(); checks++; if (rdata !== e.val) begin errors++; $display("FAIL %s: got 0x%08h want 0x%08h", e.name, rdata, e.val); end
    bus(1'b1, 1'b0, A_OUT, 32'h0AA);
    bus(1'b1, 1'b1, A_OUT, 32'h155);
    sbq.push_back('{val: 32'h0AA, name: "read_during_write"});
    bus(1'b0, 1'b0, 6'h0, 32'h0);
    e = sbq.pop_front(); checks++; if (rdata !== e.val) begin errors++; $display("FAIL %s: got 0x%08h want 0x%08h", e.name, rdata, e.val); end
    rd(A_OUT, 32'h155, "write_landed");
    e = sbq.pop_front(); checks++; if (rdata !== e.val) begin errors++; $display("FAIL %s: got 0x%08h want 0x%08h", e.name, rdata, e.val); end
  endtask

  task automatic test_n6;
    bus(1'b1, 1'b0, A_OUT, 32'h3C0);
    rd(A_OUT, 32'h3C0, "n10_out_3c0");
    e = sbq.pop_front(); checks++; if (rdata !== e.val) begin errors++; $display("FAIL %s: got 0x%08h want 0x%08h", e.name, rdata, e.val); end
    checks++; if (rdata6 !== 32'h0) begin errors++; $display("FAIL n6_out_truncated: got 0x%08h want 0x0", rdata6); end
    bus(1'b1, 1'b0, A_OUT, 32'h7FF);
    rd(A_OUT, 32'h3FF, "n10_out_7ff");
    e = sbq.pop_front(); checks++; if (rdata !== e.val) begin errors++; $display("FAIL %s: got 0x%08h want 0x%08h", e.name, rdata, e.val); end
    checks++; if (rdata6 !== 32'h3F) begin errors++; $display("FAIL n6_out_masked: got 0x%08h want 0x3f", rdata6); end
  endtask

`ifdef GPIO_DEBOUNCE_EN
  task automatic test_debounce;
    for (int j = 0; j < 12; j++) begin
      bus(1'b0, 1'b0, 6'h0, 32'h0);
      tb_val[0] = (j < 3);
    end
    rd(A_IN, {22'h0, tb_val}, "glitch_in_unchanged");
    e = sbq.pop_front(); checks++; if (rdata !== e.val) begin errors++; $display("FAIL %s: got 0x%08h want 0x%08h", e.name, rdata, e.val); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL glitch_irq: got %b want 0", irq); end
    for (int j = 0; j < 8; j++) begin
      bus(1'b0, 1'b0, 6'h0, 32'h0);
      if (j == 6) begin
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL pulse6_irq_k5: got %b want 0", irq); end
      end
      if (j == 7) begin
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL pulse6_irq_k6: got %b want 1", irq); end
      end
      tb_val[0] = (j < 6);
    end
    bus(1'b1, 1'b0, A_STAT, 32'h3FF);
  endtask
`endif

  task automatic test_async_reset;
    tb_oe = 10'h0FF;
    tb_val[2] = 1'b0;
    repeat (4 + LAT) bus(1'b0, 1'b0, 6'h0, 32'h0);
    tb_val[2] = 1'b1;
    repeat (4 + LAT) bus(1'b0, 1'b0, 6'h0, 32'h0);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL pre_reset_irq: got %b want 1", irq); end
    bus(1'b1, 1'b0, A_DIR, 32'h300);
    bus(1'b1, 1'b0, A_OUT, 32'h300);
    rd(A_OUT, 32'h300, "pre_reset_out");
    e = sbq.pop_front(); checks++; if (rdata !== e.val) begin errors++; $display("FAIL %s: got 0x%08h want 0x%08h", e.name, rdata, e.val); end
    @(negedge clk);
    we = 1'b1; re = 1'b1; addr = A_OUT; wdata = 32'h3FF;
    #2 rst_n = 1'b0;
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL async_irq: got %b want 0", irq); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL async_rdata: got 0x%08h want 0x0", rdata); end
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    rd(A_OUT, 32'h0, "post_reset_out");
    e = sbq.pop_front(); checks++; if (rdata !== e.val) begin errors++; $display("FAIL %s: got 0x%08h want 0x%08h", e.name, rdata, e.val); end
    rd(A_DIR, 32'h0, "post_reset_dir");
    e = sbq.pop_front(); checks++; if (rdata !== e.val) begin errors++; $display("FAIL %s: got 0x%08h want 0x%08h", e.name, rdata, e.val); end
    rd(A_STAT, 32'h0, "post_reset_status");
    e = sbq.pop_front(); checks++; if (rdata !== e.val) begin errors++; $display("FAIL %s: got 0x%08h want 0x%08h", e.name, rdata, e.val); end
  endtask

  initial begin
    test_reset;
    test_out_ops;
    test_rise_irq;
    test_set_wins;
    test_fall;
    test_misc;
    test_n6;
`ifdef GPIO_DEBOUNCE_EN
    test_debounce;
`endif
    test_async_reset;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpio_bank.md
# gpio_bank

Parametrised GPIO bank: N bidirectional pins with per-pin direction, atomic set/clear/toggle of output bits, a two-flop input synchroniser, and per-pin rising/falling-edge interrupt capture with a level interrupt output. Sits on the simple peripheral register bus (addr/wdata/rdata/we/re) alongside the other memory-mapped peripherals. It supersedes the fixed 10-pin controller for new designs.

## Interface
- `N`, 10: number of pins, legal range 1..32.
- `DEBOUNCE_CYCLES`, 4: consecutive stable samples required before the filtered input changes. Legal range 1..255. Used only with `GPIO_DEBOUNCE_EN`.
- `clk` in 1: single clock; all state in this domain.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `addr` in 6: byte address; `addr[5:2]` decoded, `addr[1:0]` ignored.
- `wdata` in 32: write data; bits `[31:N]` ignored.
- `rdata` out 32: registered read data; bits `[31:N]` always 0.
- `we` in 1: write strobe, one access per cycle.
- `re` in 1: read strobe.
- `gpio` inout N: pads; pin i is driven with `OUT[i]` when `DIR[i]`=1, else high-Z.
- `irq` out 1: high while any `STATUS` bit is set.

## Operation
- Register map (word index = `addr[5:2]`):
  - 0x00 `OUT`, read/write.
  - 0x04 `IN`, read-only; synchronised (and filtered) pad value. Reflects pad readback even for output pins.
  - 0x08 `DIR`, read/write; 1 = output.
  - 0x0C `SET`, write-only: `OUT |= wdata`.
  - 0x10 `CLR`, write-only: `OUT &= ~wdata`.
  - 0x14 `TGL`, write-only: `OUT ^= wdata`.
  - 0x18 `RISE_EN`, read/write.
  - 0x1C `FALL_EN`, read/write.
  - 0x20 `STATUS`, W1C.
- Write-only registers read 0. Addresses 0x24–0x3C read 0; writes to them are ignored.
- Input path: `gpio` → `sync1` → `sync2` → filtered value `f` → `IN`. `prev` holds `f` from the previous cycle.
- Edge capture:
  - `rise[i] = f[i] & ~prev[i] & RISE_EN[i]`.
  - `fall[i] = ~f[i] & prev[i] & FALL_EN[i]`.
  - `STATUS[i]` sets on `rise|fall`. It clears only when 1 is written to bit i at 0x20.
  - Set wins over a simultaneous W1C on the same bit.
- Clearing `RISE_EN`/`FALL_EN` does not clear pending `STATUS`.
- `irq = |STATUS`, driven combinationally from flops; no pulse stretching.
- Read and write in the same cycle to the same register: `rdata` returns the pre-write value.

## Timing
- Reset (`rst_n`=0, asynchronous) clears all of the following: `OUT`, `DIR`, `RISE_EN`, `FALL_EN`, `STATUS`, `sync1`, `sync2`, `f`, `prev`, debounce counters, `rdata`. Consequently all pins are high-Z, `irq`=0 and `rdata`=0.
- Reset asserted mid-operation aborts everything immediately; no access completes. Release is synchronous to the next `clk` edge via the surrounding reset synchroniser.
- Write: the register updates on the `clk` edge where `we`=1. A pad driven from `OUT`/`DIR` changes after that edge.
- Read: `rdata` is loaded on the edge where `re`=1 (latency 1) and holds its value while `re`=0.
- Input latency without debounce: a pad change set up before edge k gives `IN` updated at edge k+1 and `STATUS` set at edge k+2.
- A pad pulse shorter than one clock period may be missed. This is accepted.

## Configuration
- `GPIO_DEBOUNCE_EN` undefined: `f = sync2`, no counters.
- `GPIO_DEBOUNCE_EN` defined: each pin has a counter of width `$clog2(DEBOUNCE_CYCLES+1)`.
  - The counter increments while `sync2[i] != f[i]` and resets to 0 when they are equal.
  - When the counter reaches `DEBOUNCE_CYCLES`, `f[i]` takes `sync2[i]` and the counter resets.
  - Latency is `DEBOUNCE_CYCLES` cycles beyond the undebounced figure.
  - Glitches shorter than `DEBOUNCE_CYCLES` cycles never reach `IN` or `STATUS`.

## Test plan
- Reset, then read 0x00/0x08/0x20: `rdata`=0 each; all pads read Z; `irq`=0.
- N=10:
  - Write `DIR`=0x3FF and `OUT`=0x000.
  - `SET` 0x005 → `OUT`=0x005.
  - `TGL` 0x00F → `OUT`=0x00A.
  - `CLR` 0x002 → `OUT`=0x008; pad 3 driven 1, others 0.
- `RISE_EN`=0x001; drive pad0 0→1 before edge k:
  - `IN[0]`=1 at k+1; `STATUS`=0x001 and `irq`=1 at k+2.
  - W1C 0x001 → `irq`=0 next cycle.
- Edge on pin 2 and W1C of bit 2 in the same cycle → `STATUS[2]` stays 1. Write 0x3C0 to 0x00 with N=6 → `OUT` reads 0x00 (bits above N dropped).
- With `GPIO_DEBOUNCE_EN` and `DEBOUNCE_CYCLES`=4:
  - A 3-cycle pad pulse leaves `IN` unchanged and `STATUS` 0.
  - A 6-cycle pulse sets `IN` at k+5 and `STATUS` at k+6.
- Assert `rst_n` low mid-write with `irq` set: `irq`, `OUT`, `DIR` and `rdata` are 0 immediately, before any `clk` edge.
